// File: rtl/inta_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inta_sequencer                                                |
// | Purpose  : Interrupt-acknowledge control stage of the PIC. Counts INTA   |
// |            pulses, freezes the winning level and the mode bits at the    |
// |            first pulse, pulses ISR-set / IRR-clear, supplies the bytes   |
// |            the data bus buffer drives (CALL + vector address in MCS-80   |
// |            mode, vector number in 8086 mode) and issues AEOI clears.     |
// | Options  : `define INTA_SEQ_TIMEOUT_EN abandons a sequence when no INTA  |
// |            edge arrives within TIMEOUT_CYCLES clocks.                    |
// | Ports    : clk        system clock, rising edge                          |
// |            rst_n      asynchronous active-low reset                      |
// |            inta_n     CPU acknowledge strobe (active low, clk-synchronous)|
// |            int_req    resolver has an unmasked winner                    |
// |            int_level  winning level                                      |
// |            upm/adi/aeoi/icw1_a7_5/icw2  programmed mode bits             |
// |            int_out    INT pin to the CPU                                 |
// |            d_out/d_oe byte and drive enable for the data bus buffer      |
// |            isr_set/irr_clr/isr_clr  one-hot single-cycle pulses          |
// |            seq_busy   an acknowledge sequence is in progress             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module inta_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inta_n,
  input  logic       int_req,
  input  logic [2:0] int_level,
  input  logic       upm,
  input  logic       adi,
  input  logic       aeoi,
  input  logic [2:0] icw1_a7_5,
  input  logic [7:0] icw2,
  output logic       int_out,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic [7:0] isr_set,
  output logic [7:0] irr_clr,
  output logic [7:0] isr_clr,
  output logic       seq_busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_GAP1 = 3'd2,
    S_P2   = 3'd3,
    S_GAP2 = 3'd4,
    S_P3   = 3'd5
  } state_t;

  state_t     state, next_state;
  logic       inta_q;
  logic       fall, rise;
  logic       load;
  logic       seq_end;
  logic       timeout;

  // Values frozen at the first INTA fall for the rest of the sequence.
  logic [2:0] lvl,  lvl_nxt;
  logic       spur, spur_nxt;
  logic       upm_c,  upm_nxt;
  logic       adi_c,  adi_nxt;
  logic       aeoi_c, aeoi_nxt;
  logic [2:0] a75_c,  a75_nxt;
  logic [7:0] icw2_c, icw2_nxt;

  logic [7:0] d_out_nxt;
  logic       d_oe_nxt;
  logic [7:0] set_nxt;
  logic [7:0] isr_clr_nxt;
  logic       int_out_nxt;

  assign fall = inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;
  assign load = (state == S_IDLE) && fall;

  assign seq_busy = (state != S_IDLE);

`ifdef INTA_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES);

  // Cycles since the last INTA edge while a sequence is open.
  logic [CW-1:0] edge_cnt;

  assign timeout = (state != S_IDLE) && !fall && !rise && (edge_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if ((state == S_IDLE) || fall || rise || timeout) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    next_state = state;
    seq_end    = 1'b0;
    case (state)
      S_IDLE: if (fall) next_state = S_P1;
      S_P1:   if (rise) next_state = S_GAP1;
      S_GAP1: if (fall) next_state = S_P2;
      S_P2: begin
        if (rise) begin
          if (upm_c) begin
            next_state = S_IDLE;
            seq_end    = 1'b1;
          end else begin
            next_state = S_GAP2;
          end
        end
      end
      S_GAP2: if (fall) next_state = S_P3;
      S_P3: begin
        if (rise) begin
          next_state = S_IDLE;
          seq_end    = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
    // An abandoned sequence never issues the AEOI clear.
    if (timeout) begin
      next_state = S_IDLE;
      seq_end    = 1'b0;
    end
  end

  // Capture values as they will be after this edge, so the registered bus
  // byte for the first pulse already uses the freshly frozen mode bits.
  always_comb begin
    lvl_nxt  = lvl;
    spur_nxt = spur;
    upm_nxt  = upm_c;
    adi_nxt  = adi_c;
    aeoi_nxt = aeoi_c;
    a75_nxt  = a75_c;
    icw2_nxt = icw2_c;
    if (load) begin
      lvl_nxt  = int_req ? int_level : 3'd7;
      spur_nxt = ~int_req;
      upm_nxt  = upm;
      adi_nxt  = adi;
      aeoi_nxt = aeoi;
      a75_nxt  = icw1_a7_5;
      icw2_nxt = icw2;
    end
  end

  // Registered outputs are derived from the state being entered.
  always_comb begin
    d_out_nxt   = 8'h00;
    d_oe_nxt    = 1'b0;
    set_nxt     = 8'h00;
    isr_clr_nxt = 8'h00;
    int_out_nxt = (next_state == S_IDLE) && int_req;

    case (next_state)
      S_P1: begin
        if (!upm_nxt) begin
          d_out_nxt = 8'hCD;       // CALL opcode
          d_oe_nxt  = 1'b1;
        end
      end
      S_P2: begin
        d_oe_nxt = 1'b1;
        if (upm_nxt) begin
          d_out_nxt = {icw2_nxt[7:3], lvl_nxt};
        end else if (adi_nxt) begin
          d_out_nxt = {a75_nxt, lvl_nxt, 2'b00};
        end else begin
          d_out_nxt = {a75_nxt[2:1], lvl_nxt, 3'b000};
        end
      end
      S_P3: begin
        d_oe_nxt  = 1'b1;
        d_out_nxt = icw2_nxt;
      end
      default: begin
        d_out_nxt = 8'h00;
        d_oe_nxt  = 1'b0;
      end
    endcase

    if (load && int_req) begin
      set_nxt = 8'h01 << int_level;
    end
    if (seq_end && aeoi_c && !spur) begin
      isr_clr_nxt = 8'h01 << lvl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      inta_q   <= 1'b1;
      lvl      <= 3'd0;
      spur     <= 1'b0;
      upm_c    <= 1'b0;
      adi_c    <= 1'b0;
      aeoi_c   <= 1'b0;
      a75_c    <= 3'd0;
      icw2_c   <= 8'h00;
      int_out  <= 1'b0;
      d_out    <= 8'h00;
      d_oe     <= 1'b0;
      isr_set  <= 8'h00;
      irr_clr  <= 8'h00;
      isr_clr  <= 8'h00;
    end else begin
      state    <= next_state;
      inta_q   <= inta_n;
      lvl      <= lvl_nxt;
      spur     <= spur_nxt;
      upm_c    <= upm_nxt;
      adi_c    <= adi_nxt;
      aeoi_c   <= aeoi_nxt;
      a75_c    <= a75_nxt;
      icw2_c   <= icw2_nxt;
      int_out  <= int_out_nxt;
      d_out    <= d_out_nxt;
      d_oe     <= d_oe_nxt;
      isr_set  <= set_nxt;
      irr_clr  <= set_nxt;
      isr_clr  <= isr_clr_nxt;
    end
  end

endmodule
`default_nettype wire
